relu_stream_collector: RTL and testbench

//  Receiving end of the ReLU serial FIFO stream: accepts one ReLU result per strobe (data + ReluDONE-style valid)
//  and regroups every 2N words back into a parallel vector for the next layer / writeback.

---
 rtl/relu_stream_collector_pkg.sv | 14 +
 rtl/relu_stream_collector_bank.sv | 44 ++++
 rtl/relu_stream_collector.sv | 63 ++++++
 tb/tb_relu_stream_collector.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/relu_stream_collector_pkg.sv
// relu_stream_collector_pkg: shared widths and bank state for the ReLU stream collector.
package relu_stream_collector_pkg;

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_e;

    function automatic int relu_dw(input int n);
        return 16 + (n - 1);
    endfunction

    function automatic int cnt_w(input int g);
        return $clog2(g) + 1;
    endfunction

endpackage

// File: rtl/relu_stream_collector_bank.sv
// relu_stream_collector_bank: one G-word group buffer with fill count, full flag and close logic.
module relu_stream_collector_bank
    import relu_stream_collector_pkg::*;
#(
    parameter int DW = 17,
    parameter int G = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          write,
    input  logic          close,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] data [G-1:0],
    output logic [CW-1:0] count,
    output logic          full,
    output logic          closing,
    output bank_state_e   state
);
    localparam int AW = $clog2(G);

    logic wr;

    assign wr = write && !full;
    assign closing = !full && ((write && count == CW'(G - 1)) || (close && (write || count != '0)));
    assign state = full ? BANK_FULL : (count != '0 ? BANK_FILLING : BANK_EMPTY);

    // Contents are zeroed on release so a later flushed partial group pads with zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            full <= 1'b0;
            count <= '0;
            for (int k = 0; k < G; k++) data[k] <= '0;
        end else begin
            if (wr) begin
                data[count[AW-1:0]] <= wdata;
                count <= count + CW'(1);
            end
            if (closing) full <= 1'b1;
        end
    end

endmodule

// File: rtl/relu_stream_collector.sv
// relu_stream_collector: regroups serial ReLU results into G-word vectors through a
// ping-pong pair of banks with a valid/ready output handshake.
module relu_stream_collector
    import relu_stream_collector_pkg::*;
#(
    parameter int N = 2,
    localparam int DW = relu_dw(N),
    localparam int G = 2 * N,
    localparam int CW = cnt_w(G)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          flush,
    output logic [DW-1:0] out_data [G-1:0],
    output logic [CW-1:0] out_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overflow,
    output logic          busy
);
    logic [DW-1:0] d0 [G-1:0];
    logic [DW-1:0] d1 [G-1:0];
    logic [CW-1:0] c0, c1;
    logic          f0, f1, cl0, cl1, wsel, rsel, rel;
    bank_state_e   s0, s1;

    relu_stream_collector_bank #(.DW(DW), .G(G), .CW(CW)) b0 (
        .clk(clk), .rst(rst), .clear(rel && !rsel), .write(in_valid && !wsel),
        .close(flush && !wsel), .wdata(in_data), .data(d0), .count(c0),
        .full(f0), .closing(cl0), .state(s0)
    );

    relu_stream_collector_bank #(.DW(DW), .G(G), .CW(CW)) b1 (
        .clk(clk), .rst(rst), .clear(rel && rsel), .write(in_valid && wsel),
        .close(flush && wsel), .wdata(in_data), .data(d1), .count(c1),
        .full(f1), .closing(cl1), .state(s1)
    );

    assign out_valid = rsel ? f1 : f0;
    assign rel = out_valid && out_ready;
    assign out_count = out_valid ? (rsel ? c1 : c0) : '0;
    assign busy = s0 != BANK_EMPTY || s1 != BANK_EMPTY;

    always_comb begin
        for (int k = 0; k < G; k++) out_data[k] = !out_valid ? '0 : (rsel ? d1[k] : d0[k]);
    end

    // Fullness is judged on pre-edge state, so a same-edge release never rescues a dropped word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wsel <= 1'b0;
            rsel <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wsel <= wsel ^ (wsel ? cl1 : cl0);
            rsel <= rsel ^ rel;
            overflow <= overflow | (in_valid && (wsel ? f1 : f0));
        end
    end

endmodule

// File: tb/tb_relu_stream_collector.sv
// tb_relu_stream_collector: directed vector table plus queue-based reference model for random traffic.
module tb_relu_stream_collector;
    localparam int G = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [16:0] in_data = '0;
    logic [16:0] out_data [3:0];
    logic [2:0]  out_count;
    logic        out_valid, overflow, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    relu_stream_collector #(.N(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .out_data(out_data), .out_count(out_count), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .busy(busy)
    );

    typedef struct {
        logic [16:0] w [4];
        int          n;
    } grp_t;

    typedef struct {
        logic        v;
        logic [16:0] d;
        logic        f;
        logic        r;
        logic        ev;
        logic [2:0]  ec;
        logic        eo;
        logic [67:0] ed;
    } vec_t;

    logic [16:0] part [$];
    grp_t        grps [$];
    logic        m_ovf;

    function automatic logic [67:0] pk(input logic [16:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic v, input logic [16:0] d, input logic f, input logic r,
                                input logic ev, input logic [2:0] ec, input logic eo, input logic [67:0] ed);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.r = r; t.ev = ev; t.ec = ec; t.eo = eo; t.ed = ed;
        return t;
    endfunction

    function automatic logic [67:0] dut_data();
        return {out_data[3], out_data[2], out_data[1], out_data[0]};
    endfunction

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        part.delete();
        grps.delete();
        m_ovf = 1'b0;
    endtask

    // Groups waiting to be taken occupy banks; with two pending, nothing more can be stored.
    task automatic model_step(input logic v, input logic [16:0] d, input logic f, input logic r);
        int   pend;
        logic take;
        grp_t g;
        pend = grps.size();
        take = pend > 0 && r;
        if (v) begin
            if (pend == 2) m_ovf = 1'b1;
            else part.push_back(d);
        end
        if (pend < 2 && (part.size() == G || (f && part.size() > 0))) begin
            g.n = part.size();
            for (int k = 0; k < G; k++) g.w[k] = (k < g.n) ? part[k] : 17'h0;
            grps.push_back(g);
            part.delete();
        end
        if (take) void'(grps.pop_front());
    endtask

    task automatic model_check(input string tag);
        logic ev;
        ev = grps.size() > 0;
        chk({tag, "_valid"}, 68'(out_valid), 68'(ev));
        chk({tag, "_ovf"}, 68'(overflow), 68'(m_ovf));
        chk({tag, "_busy"}, 68'(busy), 68'(part.size() > 0 || ev));
        if (ev) begin
            chk({tag, "_count"}, 68'(out_count), 68'(grps[0].n));
            chk({tag, "_data"}, dut_data(), pk(grps[0].w[3], grps[0].w[2], grps[0].w[1], grps[0].w[0]));
        end
    endtask

    task automatic cyc(input logic v, input logic [16:0] d, input logic f, input logic r,
                       input bit check_model, input string tag);
        in_valid = v;
        in_data = d;
        flush = f;
        out_ready = r;
        model_step(v, d, f, r);
        @(posedge clk);
        #1;
        if (check_model) model_check(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        model_reset();
        #2;
        chk("rst_valid", 68'(out_valid), 68'(0));
        chk("rst_count", 68'(out_count), 68'(0));
        chk("rst_ovf", 68'(overflow), 68'(0));
        chk("rst_busy", 68'(busy), 68'(0));
        chk("rst_data", dut_data(), 68'(0));
        rst = 1'b0;
    endtask

    vec_t tbl [26];

    initial begin
        int stall, acc;
        logic r;
        tbl[0]  = mk(1, 17'h1, 0, 1, 0, 0, 0, '0);
        tbl[1]  = mk(1, 17'h2, 0, 1, 0, 0, 0, '0);
        tbl[2]  = mk(1, 17'h3, 0, 1, 0, 0, 0, '0);
        tbl[3]  = mk(1, 17'h4, 0, 1, 1, 4, 0, pk(4, 3, 2, 1));
        tbl[4]  = mk(0, 17'h0, 0, 1, 0, 0, 0, '0);
        tbl[5]  = mk(1, 17'h1, 0, 0, 0, 0, 0, '0);
        tbl[6]  = mk(1, 17'h2, 0, 0, 0, 0, 0, '0);
        tbl[7]  = mk(1, 17'h3, 0, 0, 0, 0, 0, '0);
        tbl[8]  = mk(1, 17'h4, 0, 0, 1, 4, 0, pk(4, 3, 2, 1));
        tbl[9]  = mk(1, 17'h5, 0, 0, 1, 4, 0, pk(4, 3, 2, 1));
        tbl[10] = mk(1, 17'h6, 0, 0, 1, 4, 0, pk(4, 3, 2, 1));
        tbl[11] = mk(1, 17'h7, 0, 0, 1, 4, 0, pk(4, 3, 2, 1));
        tbl[12] = mk(1, 17'h8, 0, 0, 1, 4, 0, pk(4, 3, 2, 1));
        tbl[13] = mk(1, 17'h9, 0, 0, 1, 4, 1, pk(4, 3, 2, 1));
        tbl[14] = mk(0, 17'h0, 0, 1, 1, 4, 1, pk(8, 7, 6, 5));
        tbl[15] = mk(0, 17'h0, 0, 1, 0, 0, 1, '0);
        tbl[16] = mk(1, 17'h1FFFF, 0, 1, 0, 0, 1, '0);
        tbl[17] = mk(1, 17'h0000A, 0, 1, 0, 0, 1, '0);
        tbl[18] = mk(0, 17'h0, 1, 0, 1, 2, 1, pk(0, 0, 17'hA, 17'h1FFFF));
        tbl[19] = mk(0, 17'h0, 0, 1, 0, 0, 1, '0);
        tbl[20] = mk(1, 17'h5, 0, 1, 0, 0, 1, '0);
        tbl[21] = mk(1, 17'h6, 0, 1, 0, 0, 1, '0);
        tbl[22] = mk(1, 17'h7, 1, 0, 1, 3, 1, pk(0, 7, 6, 5));
        tbl[23] = mk(0, 17'h0, 0, 1, 0, 0, 1, '0);
        tbl[24] = mk(0, 17'h0, 1, 1, 0, 0, 1, '0);
        tbl[25] = mk(0, 17'h0, 0, 1, 0, 0, 1, '0);

        #1;
        do_reset();

        for (int i = 0; i < 26; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r, 0, "tbl");
            chk($sformatf("tbl%0d_valid", i), 68'(out_valid), 68'(tbl[i].ev));
            chk($sformatf("tbl%0d_ovf", i), 68'(overflow), 68'(tbl[i].eo));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_count", i), 68'(out_count), 68'(tbl[i].ec));
                chk($sformatf("tbl%0d_data", i), dut_data(), tbl[i].ed);
            end
        end

        // Reset in the middle of a group: only the post-reset group may surface.
        do_reset();
        cyc(1, 17'hAA, 0, 0, 1, "t6a");
        cyc(1, 17'hBB, 0, 0, 1, "t6b");
        do_reset();
        cyc(1, 17'h11, 0, 0, 1, "t6c");
        cyc(1, 17'h22, 0, 0, 1, "t6d");
        cyc(1, 17'h33, 0, 0, 1, "t6e");
        cyc(1, 17'h44, 0, 0, 1, "t6f");
        chk("t6_valid", 68'(out_valid), 68'(1));
        chk("t6_count", 68'(out_count), 68'(4));
        chk("t6_data", dut_data(), pk(17'h44, 17'h33, 17'h22, 17'h11));
        chk("t6_ovf", 68'(overflow), 68'(0));
        cyc(0, 17'h0, 0, 1, 1, "t6g");

        // Sustained stream with a consumer that never stalls more than three cycles.
        stall = 0;
        acc = 0;
        for (int i = 0; i < 32; i++) begin
            r = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            stall = r ? 0 : stall + 1;
            if (grps.size() > 0 && r) acc++;
            cyc(1, 17'(i + 1), 0, r, 1, "t5");
        end
        for (int i = 0; i < 8; i++) begin
            if (grps.size() > 0) acc++;
            cyc(0, 17'h0, 0, 1, 1, "t5d");
        end
        chk("t5_groups", 68'(acc), 68'(8));
        chk("t5_ovf", 68'(overflow), 68'(0));

        // Unconstrained random traffic, including flushes and overflow.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 17'($urandom), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 2) != 0), 1, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
